branch_target_buffer: RTL and testbench

Direct-mapped branch target buffer with 2-bit saturating direction counters, feeding next-PC selection in the fetch stage of the pipelined datapath. Fetch looks up the current PC combinationally and receives a predicted target. The EX stage writes back each resolved branch or jump one entry per cycle. This removes the fixed taken-branch penalty of EX-resolved branches, and ENTRIES and WORD_W are both parametrised.

---
 rtl/branch_target_buffer.sv | 100 ++++++++++
 tb/tb_branch_target_buffer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped BTB with 2-bit direction counters
// Optional BTB_STATS_EN adds hit/update/mispredict statistics counters.
module branch_target_buffer #(
    parameter int WORD_W  = 32,
    parameter int ENTRIES = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [WORD_W-1:0] lookup_pc,
    output logic              hit,
    output logic              predict_taken,
    output logic [WORD_W-1:0] predict_target,
    input  logic              upd_valid,
    input  logic [WORD_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [WORD_W-1:0] upd_target,
    input  logic              upd_mispredict,
    input  logic              flush
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]       stat_lookups_hit,
    output logic [31:0]       stat_updates,
    output logic [31:0]       stat_mispredicts
`endif
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = WORD_W - IDX_W - 2;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    logic [ENTRIES-1:0] valid;
    logic [1:0]         ctr        [ENTRIES];
    logic [TAG_W-1:0]   tag_mem    [ENTRIES];
    logic [WORD_W-1:0]  target_mem [ENTRIES];

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic             u_hit;
    logic [1:0]       unused_pc_bits;

    assign l_idx = lookup_pc[IDX_W+1:2];
    assign l_tag = lookup_pc[WORD_W-1:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[WORD_W-1:IDX_W+2];
    assign unused_pc_bits = upd_pc[1:0];

    // Lookup reads stored state only, so a same-cycle update is never bypassed.
    assign hit            = valid[l_idx] && (tag_mem[l_idx] == l_tag);
    assign predict_taken  = hit && ctr[l_idx][1];
    assign predict_target = predict_taken ? target_mem[l_idx] : lookup_pc + WORD_W'(4);

    assign u_hit = valid[u_idx] && (tag_mem[u_idx] == u_tag);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_WNT;
        end else if (flush) begin
            valid <= '0;
        end else if (upd_valid) begin
            if (u_hit) begin
                if (upd_taken && ctr[u_idx] != CTR_ST)
                    ctr[u_idx] <= ctr[u_idx] + 2'd1;
                else if (!upd_taken && ctr[u_idx] != CTR_SNT)
                    ctr[u_idx] <= ctr[u_idx] - 2'd1;
            end else if (upd_taken) begin
                valid[u_idx] <= 1'b1;
                ctr[u_idx]   <= CTR_WT;
            end
        end
    end

    // Tag/target need no reset: they are only observed behind a set valid bit.
    always_ff @(posedge CLK) begin
        if (upd_valid && !flush && upd_taken) begin
            tag_mem[u_idx]    <= u_tag;
            target_mem[u_idx] <= upd_target;
        end
    end

`ifdef BTB_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_lookups_hit <= '0;
            stat_updates     <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (hit)                         stat_lookups_hit <= stat_lookups_hit + 32'd1;
            if (upd_valid)                   stat_updates     <= stat_updates + 32'd1;
            if (upd_valid && upd_mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`else
    logic unused_mispredict;
    assign unused_mispredict = upd_mispredict;
`endif
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - directed self-checking bench for branch_target_buffer
module tb_branch_target_buffer;
    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] lookup_pc;
    logic        hit, predict_taken;
    logic [31:0] predict_target;
    logic        upd_valid, upd_taken, upd_mispredict, flush;
    logic [31:0] upd_pc, upd_target;
`ifdef BTB_STATS_EN
    logic [31:0] stat_lookups_hit, stat_updates, stat_mispredicts;
`endif

    int errors = 0;
    int checks = 0;

    branch_target_buffer #(.WORD_W(32), .ENTRIES(16)) dut (
        .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc),
        .hit(hit), .predict_taken(predict_taken), .predict_target(predict_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict), .flush(flush)
`ifdef BTB_STATS_EN
        , .stat_lookups_hit(stat_lookups_hit), .stat_updates(stat_updates),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic eh, input logic et, input logic [31:0] etgt);
        lookup_pc = pc;
        #1;
        checks++;
        assert (hit === eh) else begin
            errors++;
            $error("FAIL %s hit got %0b exp %0b", tag, hit, eh);
        end
        checks++;
        assert (predict_taken === et) else begin
            errors++;
            $error("FAIL %s taken got %0b exp %0b", tag, predict_taken, et);
        end
        checks++;
        assert (predict_target === etgt) else begin
            errors++;
            $error("FAIL %s target got %h exp %h", tag, predict_target, etgt);
        end
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic mp);
        @(negedge CLK);
        upd_valid = 1'b1; upd_pc = pc; upd_taken = tk;
        upd_target = tgt; upd_mispredict = mp;
        @(posedge CLK);
        #1;
        upd_valid = 1'b0; upd_mispredict = 1'b0;
    endtask

`ifdef BTB_STATS_EN
    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask
`endif

    initial begin
        nRST = 1'b0; lookup_pc = 32'h40; upd_valid = 1'b0; upd_pc = '0;
        upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0; flush = 1'b0;
        #12;
        look("reset_0x40", 32'h40, 1'b0, 1'b0, 32'h44);
        look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;

        upd(32'h40, 1'b1, 32'h100, 1'b0);
        look("alloc_0x40", 32'h40, 1'b1, 1'b1, 32'h100);

        // WT -> ST and saturated; a wrapping counter would end up not-taken.
        for (int i = 0; i < 4; i++) upd(32'h40, 1'b1, 32'h100, 1'b0);
        upd(32'h40, 1'b0, 32'h0, 1'b0);
        look("st_to_wt", 32'h40, 1'b1, 1'b1, 32'h100);
        upd(32'h40, 1'b0, 32'h0, 1'b0);
        look("wt_to_wnt", 32'h40, 1'b1, 1'b0, 32'h44);
        upd(32'h40, 1'b0, 32'h0, 1'b0);
        upd(32'h40, 1'b0, 32'h0, 1'b0);
        upd(32'h40, 1'b1, 32'h120, 1'b0);
        look("snt_sat_wnt", 32'h40, 1'b1, 1'b0, 32'h44);

        look("alias_miss_0x80", 32'h80, 1'b0, 1'b0, 32'h84);
        upd(32'h84, 1'b0, 32'h500, 1'b0);
        look("nt_miss_noalloc", 32'h84, 1'b0, 1'b0, 32'h88);
        upd(32'h80, 1'b1, 32'h200, 1'b0);
        look("alias_evict_0x40", 32'h40, 1'b0, 1'b0, 32'h44);
        look("alias_0x80", 32'h80, 1'b1, 1'b1, 32'h200);

        // Same-cycle lookup and update: pre-update contents before the edge.
        @(negedge CLK);
        upd_valid = 1'b1; upd_pc = 32'h80; upd_taken = 1'b0; upd_target = 32'h0;
        look("same_cycle_pre", 32'h80, 1'b1, 1'b1, 32'h200);
        @(posedge CLK);
        #1;
        upd_valid = 1'b0;
        look("same_cycle_post", 32'h80, 1'b1, 1'b0, 32'h84);

        upd(32'h44, 1'b1, 32'h300, 1'b0);
        look("alloc_0x44", 32'h44, 1'b1, 1'b1, 32'h300);
        @(negedge CLK);
        flush = 1'b1; upd_valid = 1'b1; upd_pc = 32'hC0; upd_taken = 1'b1; upd_target = 32'h400;
        @(posedge CLK);
        #1;
        flush = 1'b0; upd_valid = 1'b0;
        look("flush_0x80", 32'h80, 1'b0, 1'b0, 32'h84);
        look("flush_0x44", 32'h44, 1'b0, 1'b0, 32'h48);
        look("flush_0xC0", 32'hC0, 1'b0, 1'b0, 32'hC4);

        upd(32'h40, 1'b1, 32'h100, 1'b0);
        upd(32'h48, 1'b1, 32'h108, 1'b0);
        upd(32'h4C, 1'b1, 32'h10C, 1'b0);
        look("alloc3_0x48", 32'h48, 1'b1, 1'b1, 32'h108);
        @(negedge CLK);
        #2;
        nRST = 1'b0;
        look("rst_0x40", 32'h40, 1'b0, 1'b0, 32'h44);
        look("rst_0x48", 32'h48, 1'b0, 1'b0, 32'h4C);
        look("rst_0x4C", 32'h4C, 1'b0, 1'b0, 32'h50);
        @(negedge CLK);
        nRST = 1'b1;
        upd(32'h4C, 1'b1, 32'h10C, 1'b0);
        look("rst_ctr_wt", 32'h4C, 1'b1, 1'b1, 32'h10C);

`ifdef BTB_STATS_EN
        @(negedge CLK);
        nRST = 1'b0;
        lookup_pc = 32'h1000;
        @(negedge CLK);
        nRST = 1'b1;
        upd(32'h40, 1'b1, 32'h100, 1'b1);
        upd(32'h40, 1'b1, 32'h100, 1'b0);
        upd(32'h44, 1'b0, 32'h0,   1'b1);
        upd(32'h48, 1'b1, 32'h108, 1'b0);
        upd(32'h40, 1'b0, 32'h0,   1'b0);
        chk32("stat_updates", stat_updates, 32'd5);
        chk32("stat_mispredicts", stat_mispredicts, 32'd2);
        chk32("stat_hits_idle", stat_lookups_hit, 32'd0);
        @(negedge CLK);
        lookup_pc = 32'h48;
        @(negedge CLK);
        @(negedge CLK);
        lookup_pc = 32'h1000;
        chk32("stat_hits_two", stat_lookups_hit, 32'd2);
        nRST = 1'b0;
        #1;
        chk32("stat_updates_rst", stat_updates, 32'd0);
        chk32("stat_mispredicts_rst", stat_mispredicts, 32'd0);
        nRST = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
